// File: rtl/vmask_unpack.sv
// Packed mask word to per-beat element mask / byte-enable expander.
// Optional complement path: define VMASK_UNPACK_INVERT_EN.
module vmask_unpack #(
  parameter int REQ_DATA_WIDTH    = 64,
  parameter int REQ_BYTE_EN_WIDTH = REQ_DATA_WIDTH / 8,
  parameter int REQ_ADDR_WIDTH    = 32,
  parameter int SEW_WIDTH         = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_DATA_WIDTH-1:0]    in_mask,
  input  logic                         in_mask_valid,
  output logic                         in_mask_ready,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SEW_WIDTH-1:0]         in_sew,
  input  logic [REQ_ADDR_WIDTH-1:0]    in_addr,
  input  logic                         in_req_start,
  input  logic                         in_req_end,
  output logic [REQ_BYTE_EN_WIDTH-1:0] out_mask,
  output logic [REQ_BYTE_EN_WIDTH-1:0] out_be,
  output logic [REQ_ADDR_WIDTH-1:0]    out_addr,
  output logic                         out_valid
`ifdef VMASK_UNPACK_INVERT_EN
  ,
  input  logic                         in_invert
`endif
);

  localparam int BE_W  = REQ_BYTE_EN_WIDTH;
  localparam int PTR_W = $clog2(REQ_DATA_WIDTH);
  localparam int IDX_W = $clog2(BE_W);

  typedef enum logic {
    EMPTY,
    ACTIVE
  } state_t;

  state_t                      state_q, state_d;
  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [REQ_DATA_WIDTH-1:0]   mask_q, mask_d;

  logic                        valid_d;
  logic [BE_W-1:0]             omask_d, obe_d;
  logic [REQ_ADDR_WIDTH-1:0]   addr_d;

  logic                        accept;
  logic                        rel;
  logic                        load;
  logic [PTR_W-1:0]            eff_ptr;
  logic [PTR_W:0]              elem_cnt;
  logic [PTR_W:0]              sum;
  logic [BE_W-1:0]             keep;
  logic [BE_W-1:0]             raw;
  logic [BE_W-1:0]             slice;
  logic [REQ_DATA_WIDTH+BE_W-1:0] ext;

  // Replicate each element bit across the bytes it covers.
  function automatic logic [BE_W-1:0] expand(
    input logic [BE_W-1:0]      m,
    input logic [SEW_WIDTH-1:0] sew
  );
    logic [BE_W-1:0] be;
    be = '0;
    for (int b = 0; b < BE_W; b++) begin
      be[b] = m[IDX_W'(b) >> sew];
    end
    return be;
  endfunction

  assign in_ready = (state_q == ACTIVE);
  assign accept   = in_valid & in_ready;

  assign eff_ptr  = in_req_start ? '0 : ptr_q;
  assign elem_cnt = (PTR_W+1)'(BE_W) >> in_sew;
  assign sum      = {1'b0, eff_ptr} + elem_cnt;
  assign keep     = ~({BE_W{1'b1}} << elem_cnt);

  // Zero guard bits let a misaligned pointer read past the word top.
  assign ext = {{BE_W{1'b0}}, mask_q};
  assign raw = ext[eff_ptr +: BE_W];

`ifdef VMASK_UNPACK_INVERT_EN
  assign slice = (in_invert ? ~raw : raw) & keep;
`else
  assign slice = raw & keep;
`endif

  assign rel = accept &
               ((sum == (PTR_W+1)'(REQ_DATA_WIDTH)) | in_req_end);

  assign in_mask_ready = (state_q == EMPTY) | rel;
  assign load          = in_mask_valid & in_mask_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    valid_d = accept;
    omask_d = '0;
    obe_d   = '0;
    addr_d  = out_addr;
    if (accept) begin
      omask_d = slice;
      obe_d   = expand(slice, in_sew);
      addr_d  = in_addr;
      ptr_d   = sum[PTR_W-1:0];
      if (rel) begin
        state_d = EMPTY;
        ptr_d   = '0;
      end
    end
    // A refill in the release cycle overrides the release.
    if (load) begin
      mask_d  = in_mask;
      ptr_d   = '0;
      state_d = ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      ptr_q     <= '0;
      mask_q    <= '0;
      out_valid <= 1'b0;
      out_mask  <= '0;
      out_be    <= '0;
      out_addr  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      mask_q    <= mask_d;
      out_valid <= valid_d;
      out_mask  <= omask_d;
      out_be    <= obe_d;
      out_addr  <= addr_d;
    end
  end

endmodule

// File: tb/tb_vmask_unpack.sv
// Scoreboard bench for vmask_unpack.
// Expected beats are queued on accept and compared on out_valid.
module tb_vmask_unpack;

  logic        clk;
  logic        rst;
  logic [63:0] in_mask;
  logic        in_mask_valid;
  logic        in_mask_ready;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sew;
  logic [31:0] in_addr;
  logic        in_req_start;
  logic        in_req_end;
  logic [7:0]  out_mask;
  logic [7:0]  out_be;
  logic [31:0] out_addr;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 0;

  logic [47:0] exp_q[$];

  vmask_unpack dut (
    .clk           (clk),
    .rst           (rst),
    .in_mask       (in_mask),
    .in_mask_valid (in_mask_valid),
    .in_mask_ready (in_mask_ready),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sew        (in_sew),
    .in_addr       (in_addr),
    .in_req_start  (in_req_start),
    .in_req_end    (in_req_end),
    .out_mask      (out_mask),
    .out_be        (out_be),
    .out_addr      (out_addr),
    .out_valid     (out_valid)
`ifdef VMASK_UNPACK_INVERT_EN
    ,
    .in_invert     (1'b0)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] be_of(input logic [7:0] m,
                                       input logic [1:0] sew);
    logic [7:0] be;
    int w;
    int n;
    be = '0;
    w  = 1 << sew;
    n  = 8 >> sew;
    for (int e = 0; e < n; e++)
      for (int r = 0; r < w; r++)
        be[e*w + r] = m[e];
    return be;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexp_out", 64'(out_mask), 64'hx);
        end else begin
          logic [47:0] e;
          e = exp_q.pop_front();
          chk("out_mask", 64'(out_mask), 64'(e[47:40]));
          chk("out_be",   64'(out_be),   64'(e[39:32]));
          chk("out_addr", 64'(out_addr), 64'(e[31:0]));
        end
      end else begin
        chk("idle_zero", 64'({out_mask, out_be}), 64'h0);
      end
    end
  end

  task automatic load_word(input logic [63:0] w, input bit keep);
    int n;
    n = 0;
    in_mask = w;
    in_mask_valid = 1;
    @(negedge clk);
    while (!in_mask_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_mask_ready) chk("load_timeout", 64'(in_mask_ready), 64'h1);
    @(posedge clk);
    #1;
    if (!keep) in_mask_valid = 0;
  endtask

  task automatic beat(input logic [1:0] sew, input logic [31:0] addr,
                      input logic st, input logic en,
                      input logic [7:0] em,
                      output int waited, output logic mrdy);
    in_sew = sew;
    in_addr = addr;
    in_req_start = st;
    in_req_end = en;
    in_valid = 1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk("beat_timeout", 64'(in_ready), 64'h1);
    else exp_q.push_back({em, be_of(em, sew), addr});
    mrdy = in_mask_ready;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_req_start = 0;
    in_req_end = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wt;
    logic mr;
    logic [63:0] a, b, w;

    rst = 1;
    in_mask = '0;
    in_mask_valid = 0;
    in_valid = 0;
    in_sew = 0;
    in_addr = 0;
    in_req_start = 0;
    in_req_end = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_mask",  64'(out_mask),  64'h0);
    chk("rst_out_be",    64'(out_be),    64'h0);
    chk("rst_out_addr",  64'(out_addr),  64'h0);
    chk("rst_mask_rdy",  64'(in_mask_ready), 64'h1);
    chk("rst_in_ready",  64'(in_ready),  64'h0);
    mon_en = 1;

    // Test 1
    load_word(64'h00000000000000A5, 0);
    beat(2'd0, 32'h100, 1, 1, 8'hA5, wt, mr);
    chk("t1_mask_rdy", 64'(mr), 64'h1);

    // Test 2
    load_word(64'h00000000000000C6, 0);
    beat(2'd1, 32'h200, 1, 0, 8'h06, wt, mr);
    beat(2'd1, 32'h208, 0, 0, 8'h0C, wt, mr);
    beat(2'd1, 32'h210, 0, 1, 8'h00, wt, mr);

    // Test 3
    load_word(64'h8000000000000001, 0);
    for (int i = 0; i < 64; i++) begin
      beat(2'd3, 32'h1000 + 32'(i*8), (i == 0), 0,
           (i == 0 || i == 63) ? 8'h01 : 8'h00, wt, mr);
      if (i == 62) chk("t3_busy", 64'(mr), 64'h0);
    end
    chk("t3_release_rdy", 64'(mr), 64'h1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_in_ready", 64'(in_ready), 64'h0);
      @(posedge clk);
      #1;
    end

    // Test 4
    a = 64'h0123456789ABCDEF;
    b = 64'hFEDCBA9876543210;
    load_word(a, 1);
    in_mask = b;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) in_mask_valid = 0;
      beat(2'd0, 32'h2000 + 32'(k*8), (k == 0), 0,
           (k < 8) ? a[8*k +: 8] : b[8*(k-8) +: 8], wt, mr);
      if (k == 3) chk("t4_busy", 64'(mr), 64'h0);
      if (k == 7) chk("t4_refill_rdy", 64'(mr), 64'h1);
      if (k == 8) chk("t4_no_bubble", 64'(wt), 64'h0);
    end

    // Test 5
    w = 64'h000000000000002D;
    load_word(w, 0);
    beat(2'd2, 32'h300, 1, 0, 8'h1, wt, mr);
    beat(2'd2, 32'h308, 0, 0, 8'h3, wt, mr);
    beat(2'd2, 32'h310, 0, 1, 8'h2, wt, mr);
    chk("t5_release", 64'(in_ready), 64'h0);
    load_word(64'hFFFF000000000002, 0);
    beat(2'd2, 32'h400, 1, 0, 8'h2, wt, mr);
    beat(2'd2, 32'h408, 0, 0, 8'h0, wt, mr);
    beat(2'd2, 32'h410, 1, 1, 8'h2, wt, mr);

    // Test 6
    load_word(64'hFFFFFFFFFFFFFFFF, 0);
    beat(2'd0, 32'h500, 1, 0, 8'hFF, wt, mr);
    beat(2'd0, 32'h508, 0, 0, 8'hFF, wt, mr);
    rst = 1;
    @(posedge clk);
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'h0);
    chk("t6_in_ready",  64'(in_ready),  64'h0);
    chk("t6_mask_rdy",  64'(in_mask_ready), 64'h1);
    rst = 0;
    in_valid = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_discarded", 64'(in_ready), 64'h0);
    in_valid = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
